// File: rtl/rs_multi_cdb.sv
// Reservation station with multi-channel CDB snooping.
// Holds DEPTH waiting instructions and captures operands from CDB_PORTS
// broadcast channels. Each cycle it dispatches one ready entry into a
// registered valid/ready output stage.
// Optional build macro RS_AGE_SELECT_EN: dispatch the oldest ready entry
// instead of the lowest-index ready entry.
module rs_multi_cdb #(
  parameter int DEPTH     = 16,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int IMM_W     = 32,
  parameter int ADDR_W    = 32,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          clear,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [TAG_W-1:0]              issue_dest,
  input  logic [OP_W-1:0]               issue_op,
  input  logic [TAG_W-1:0]              issue_q1,
  input  logic [TAG_W-1:0]              issue_q2,
  input  logic [DATA_W-1:0]             issue_v1,
  input  logic [DATA_W-1:0]             issue_v2,
  input  logic [IMM_W-1:0]              issue_imm,
  input  logic [ADDR_W-1:0]             issue_pc,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
  output logic                          ex_valid,
  input  logic                          ex_ready,
  output logic [OP_W-1:0]               ex_op,
  output logic [DATA_W-1:0]             ex_v1,
  output logic [DATA_W-1:0]             ex_v2,
  output logic [IMM_W-1:0]              ex_imm,
  output logic [ADDR_W-1:0]             ex_pc,
  output logic [TAG_W-1:0]              ex_dest,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [TAG_W-1:0]  q1_q   [DEPTH];
  logic [TAG_W-1:0]  q1_d   [DEPTH];
  logic [TAG_W-1:0]  q2_q   [DEPTH];
  logic [TAG_W-1:0]  q2_d   [DEPTH];
  logic [DATA_W-1:0] v1_q   [DEPTH];
  logic [DATA_W-1:0] v1_d   [DEPTH];
  logic [DATA_W-1:0] v2_q   [DEPTH];
  logic [DATA_W-1:0] v2_d   [DEPTH];
  logic [IMM_W-1:0]  imm_q  [DEPTH];
  logic [IMM_W-1:0]  imm_d  [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
`ifdef RS_AGE_SELECT_EN
  // Rank 0 is the oldest occupied entry; ranks stay dense 0..count-1.
  logic [IDX_W-1:0]  age_q  [DEPTH];
  logic [IDX_W-1:0]  age_d  [DEPTH];
`endif

  logic [CNT_W-1:0]  count_q, count_d;
  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_v1_q, ex_v1_d;
  logic [DATA_W-1:0] ex_v2_q, ex_v2_d;
  logic [IMM_W-1:0]  ex_imm_q, ex_imm_d;
  logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
  logic [TAG_W-1:0]  ex_dest_q, ex_dest_d;

  logic [DEPTH-1:0]  ready_vec;
  logic              sel_found, free_found;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              out_load, do_issue, do_disp;
  logic [DATA_W:0]   byp1, byp2, wk1, wk2;

  // Returns {hit, data} for a tag; lowest matching channel wins, tag 0 never hits.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag,
                                             input logic [CDB_PORTS-1:0] cv,
                                             input logic [CDB_PORTS*TAG_W-1:0] ct,
                                             input logic [CDB_PORTS*DATA_W-1:0] cd);
    logic [DATA_W:0] r;
    r = '0;
    for (int unsigned k = 0; k < CDB_PORTS; k++) begin
      if (!r[DATA_W] && cv[k] && (tag != '0) && (ct[k*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, cd[k*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign issue_ready = (count_q < CNT_W'(DEPTH));
  assign out_load    = !ex_valid_q || ex_ready;
  assign do_issue    = issue_valid && issue_ready && free_found;
  assign do_disp     = out_load && sel_found;
  assign byp1        = snoop(issue_q1, cdb_valid, cdb_tag, cdb_data);
  assign byp2        = snoop(issue_q2, cdb_valid, cdb_tag, cdb_data);

  // Entry readiness from registered state only.
  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready_vec[i] = vld_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
  end

  // Pick the dispatch candidate and the lowest free slot.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef RS_AGE_SELECT_EN
      if (ready_vec[i] && (!sel_found || (age_q[i] < age_q[sel_idx]))) begin
`else
      if (ready_vec[i] && !sel_found) begin
`endif
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!vld_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next state: wakeup, dispatch, issue with bypass, occupancy.
  always_comb begin
    vld_d      = vld_q;
    count_d    = count_q;
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_v1_d    = ex_v1_q;
    ex_v2_d    = ex_v2_q;
    ex_imm_d   = ex_imm_q;
    ex_pc_d    = ex_pc_q;
    ex_dest_d  = ex_dest_q;
    wk1        = '0;
    wk2        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      op_d[i]   = op_q[i];
      dest_d[i] = dest_q[i];
      q1_d[i]   = q1_q[i];
      q2_d[i]   = q2_q[i];
      v1_d[i]   = v1_q[i];
      v2_d[i]   = v2_q[i];
      imm_d[i]  = imm_q[i];
      pc_d[i]   = pc_q[i];
`ifdef RS_AGE_SELECT_EN
      age_d[i]  = age_q[i];
      if (do_disp && vld_q[i] && (age_q[i] > age_q[sel_idx])) begin
        age_d[i] = age_q[i] - IDX_W'(1);
      end
`endif
      if (vld_q[i]) begin
        wk1 = snoop(q1_q[i], cdb_valid, cdb_tag, cdb_data);
        wk2 = snoop(q2_q[i], cdb_valid, cdb_tag, cdb_data);
        if (wk1[DATA_W]) begin
          q1_d[i] = '0;
          v1_d[i] = wk1[DATA_W-1:0];
        end
        if (wk2[DATA_W]) begin
          q2_d[i] = '0;
          v2_d[i] = wk2[DATA_W-1:0];
        end
      end
    end

    if (out_load) begin
      ex_valid_d = sel_found;
      if (sel_found) begin
        vld_d[sel_idx] = 1'b0;
        ex_op_d        = op_q[sel_idx];
        ex_v1_d        = v1_q[sel_idx];
        ex_v2_d        = v2_q[sel_idx];
        ex_imm_d       = imm_q[sel_idx];
        ex_pc_d        = pc_q[sel_idx];
        ex_dest_d      = dest_q[sel_idx];
      end
    end

    if (do_issue) begin
      vld_d[free_idx]  = 1'b1;
      op_d[free_idx]   = issue_op;
      dest_d[free_idx] = issue_dest;
      imm_d[free_idx]  = issue_imm;
      pc_d[free_idx]   = issue_pc;
      q1_d[free_idx]   = byp1[DATA_W] ? '0 : issue_q1;
      v1_d[free_idx]   = byp1[DATA_W] ? byp1[DATA_W-1:0] : issue_v1;
      q2_d[free_idx]   = byp2[DATA_W] ? '0 : issue_q2;
      v2_d[free_idx]   = byp2[DATA_W] ? byp2[DATA_W-1:0] : issue_v2;
`ifdef RS_AGE_SELECT_EN
      // Newest rank equals the occupancy left after this cycle's dispatch.
      age_d[free_idx]  = IDX_W'(count_q - (do_disp ? CNT_W'(1) : CNT_W'(0)));
`endif
    end

    if (do_issue && !do_disp) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_issue && do_disp) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State register: reset, flush, freeze when !rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_v1_q    <= '0;
      ex_v2_q    <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      ex_dest_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
`ifdef RS_AGE_SELECT_EN
        age_q[i]  <= '0;
`endif
      end
    end else if (clear) begin
      vld_q      <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
`ifdef RS_AGE_SELECT_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
`endif
    end else if (rdy) begin
      vld_q      <= vld_d;
      count_q    <= count_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_v1_q    <= ex_v1_d;
      ex_v2_q    <= ex_v2_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
      ex_dest_q  <= ex_dest_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]   <= op_d[i];
        dest_q[i] <= dest_d[i];
        q1_q[i]   <= q1_d[i];
        q2_q[i]   <= q2_d[i];
        v1_q[i]   <= v1_d[i];
        v2_q[i]   <= v2_d[i];
        imm_q[i]  <= imm_d[i];
        pc_q[i]   <= pc_d[i];
`ifdef RS_AGE_SELECT_EN
        age_q[i]  <= age_d[i];
`endif
      end
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_v1    = ex_v1_q;
  assign ex_v2    = ex_v2_q;
  assign ex_imm   = ex_imm_q;
  assign ex_pc    = ex_pc_q;
  assign ex_dest  = ex_dest_q;
  assign count    = count_q;

endmodule
